led_sequencer: RTL and testbench

Parametrised LED pattern engine driving a bank of active-low board LEDs from a single clock. Replaces the hard-wired static LED pattern with four runtime-selectable modes: static, running light, ping-pong and blink. An internal prescaler steps the animation. Sits directly on the LED pins at top level; mode and pattern come from switches or a control block.

---
 rtl/led_sequencer.sv | 139 +++++++++++++
 tb/tb_led_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_sequencer
// Purpose  : LED pattern engine (static / running / ping-pong / blink) with an
//            animation prescaler. Optional brightness PWM: LED_SEQUENCER_PWM_EN
// Revision : 1.0 - initial release
// ============================================================================
module led_sequencer #(
    parameter int          LED_NUM      = 8,
    parameter int          TICK_DIV     = 12500000,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter logic [31:0] INIT_PATTERN = 32'h0000_00AA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               pat_sel,
    input  logic [LED_NUM-1:0] pattern,
    input  logic               pause,
    input  logic [7:0]         duty,
    output logic [LED_NUM-1:0] led,
    output logic               step
);

    localparam int PW = $clog2(LED_NUM);
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] c_POS_LAST = PW'(LED_NUM - 1);
    localparam logic [PW-1:0] c_POS_PEN  = PW'(LED_NUM - 2);
    localparam logic [PW-1:0] c_POS_ONE  = PW'(1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] c_MODE_STATIC = 2'd0;
    localparam logic [1:0] c_MODE_RUN    = 2'd1;
    localparam logic [1:0] c_MODE_PING   = 2'd2;
    localparam logic [1:0] c_MODE_BLINK  = 2'd3;

    localparam logic [LED_NUM-1:0] c_UNLIT = {LED_NUM{ACTIVE_LOW}};

    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_pos;
    logic               r_dir_down;
    logic               r_phase_on;
    logic [1:0]         r_mode_q;
    logic               w_mode_chg;
    logic               w_tick;
    logic [LED_NUM-1:0] w_sel;
    logic [LED_NUM-1:0] w_onehot;
    logic [LED_NUM-1:0] w_mask;
    logic [LED_NUM-1:0] w_drive;

    assign w_mode_chg = (mode != r_mode_q);
    // A mode change restarts the animation, so it also swallows a coincident tick.
    assign w_tick     = !pause && !w_mode_chg && (r_cnt == c_CNT_LAST);
    assign w_sel      = pat_sel ? pattern : INIT_PATTERN[LED_NUM-1:0];
    assign w_onehot   = LED_NUM'(1) << r_pos;

    always_comb begin
        w_mask = '0;
        case (r_mode_q)
            c_MODE_STATIC: w_mask = w_sel;
            c_MODE_RUN:    w_mask = w_onehot;
            c_MODE_PING:   w_mask = w_onehot;
            c_MODE_BLINK:  w_mask = r_phase_on ? w_sel : '0;
            default:       w_mask = '0;
        endcase
    end

`ifdef LED_SEQUENCER_PWM_EN
    logic [7:0] r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= 8'd0;
        end else begin
            r_pwm <= r_pwm + 8'd1;
        end
    end

    assign w_drive = w_mask & {LED_NUM{(r_pwm < duty)}};
`else
    logic w_unused_duty;
    assign w_unused_duty = ^duty;
    assign w_drive       = w_mask;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_pos      <= '0;
            r_dir_down <= 1'b0;
            r_phase_on <= 1'b1;
            r_mode_q   <= c_MODE_STATIC;
            step       <= 1'b0;
            led        <= c_UNLIT;
        end else begin
            step <= w_tick;
            led  <= w_drive ^ c_UNLIT;
            if (w_mode_chg) begin
                r_mode_q   <= mode;
                r_cnt      <= '0;
                r_pos      <= '0;
                r_dir_down <= 1'b0;
                r_phase_on <= 1'b1;
            end else if (!pause) begin
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
                if (w_tick) begin
                    case (r_mode_q)
                        c_MODE_RUN: begin
                            r_pos <= (r_pos == c_POS_LAST) ? '0 : r_pos + 1'b1;
                        end
                        c_MODE_PING: begin
                            // Reverse at the ends so the end LEDs never show twice in a row.
                            if (!r_dir_down) begin
                                if (r_pos == c_POS_LAST) begin
                                    r_dir_down <= 1'b1;
                                    r_pos      <= c_POS_PEN;
                                end else begin
                                    r_pos <= r_pos + 1'b1;
                                end
                            end else begin
                                if (r_pos == '0) begin
                                    r_dir_down <= 1'b0;
                                    r_pos      <= c_POS_ONE;
                                end else begin
                                    r_pos <= r_pos - 1'b1;
                                end
                            end
                        end
                        c_MODE_BLINK: r_phase_on <= ~r_phase_on;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sequencer
// Purpose  : Randomised bench for led_sequencer against a tick-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

    localparam int N = 8;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic         pat_sel = 1'b0;
    logic [N-1:0] pattern = 8'h00;
    logic         pause = 1'b0;
    logic [7:0]   duty = 8'd128;
    logic [N-1:0] led;
    logic         step;

    int n_checks = 0;
    int n_errors = 0;

    led_sequencer #(
        .LED_NUM      (N),
        .TICK_DIV     (T),
        .ACTIVE_LOW   (1'b1),
        .INIT_PATTERN (32'h0000_00AA)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .pat_sel (pat_sel),
        .pattern (pattern),
        .pause   (pause),
        .duty    (duty),
        .led     (led),
        .step    (step)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Lit-mask from mode and number of completed ticks since the last clear.
    function automatic logic [N-1:0] model_mask(input int mq, input int k, input logic [N-1:0] sel);
        logic [N-1:0] one;
        int           idx;
        one = 1;
        case (mq)
            0:       return sel;
            1:       return one << (k % N);
            2: begin
                idx = k % (2 * N - 2);
                return one << ((idx < N) ? idx : (2 * N - 2 - idx));
            end
            default: return ((k % 2) == 0) ? sel : '0;
        endcase
    endfunction

    int           m_mode_q = 0;
    int           m_u      = 0;
    int           m_pwm    = 0;
    logic         m_step   = 1'b0;
    logic [N-1:0] m_led    = '1;

    initial begin : main
        logic [N-1:0] sel;
        logic [N-1:0] mask;
        int           seg_left;
        seg_left = 50;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk);
            if (rst) begin
                m_mode_q = 0;
                m_u      = 0;
                m_pwm    = 0;
                m_step   = 1'b0;
                m_led    = '1;
            end else begin
                sel  = pat_sel ? pattern : 8'hAA;
                mask = model_mask(m_mode_q, m_u / T, sel);
`ifdef LED_SEQUENCER_PWM_EN
                if (!(m_pwm < int'(duty))) mask = '0;
`endif
                m_led = ~mask;
                m_pwm = (m_pwm + 1) % 256;
                if (int'(mode) != m_mode_q) begin
                    m_mode_q = int'(mode);
                    m_u      = 0;
                    m_step   = 1'b0;
                end else if (pause) begin
                    m_step = 1'b0;
                end else begin
                    m_step = ((m_u % T) == T - 1);
                    m_u++;
                end
            end
            #1;
            check_value(rst ? "led_reset" : "led", 32'(led), 32'(m_led));
            check_value(rst ? "step_reset" : "step", 32'(step), 32'(m_step));

            @(negedge clk);
            rst = (cyc < 2) || ($urandom_range(0, 599) == 0);
            seg_left--;
            if (seg_left <= 0) begin
                mode     = 2'($urandom_range(0, 3));
                seg_left = $urandom_range(30, 220);
            end
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 9) == 0) pattern = 8'($urandom);
            if ($urandom_range(0, 39) == 0) pat_sel = ~pat_sel;
            if ($urandom_range(0, 49) == 0) duty = 8'($urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
